// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD converter arbiter.
package bcd_pkg;

   localparam int BCD_DIGITS = 7;
   localparam int BCD_W      = 4 * BCD_DIGITS;

   // Digit 6 is the most significant nibble, digit 0 the least.
   typedef logic [BCD_DIGITS-1:0][3:0] bcd7_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DELIVER
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo N. Reusable by any shared-resource controller.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int pos;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      pos   = 0;
      for (int off = 0; off < N; off++) begin
         pos = int'(ptr_i) + off;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!any_o && req_i[IDX_W'(pos)]) begin
            any_o               = 1'b1;
            idx_o               = IDX_W'(pos);
            gnt_o[IDX_W'(pos)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sharing of one binary-to-BCD converter among N_REQ requesters.
// Optional watchdog on the WAIT state is built when BCD_ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a request while the converter is ready
// ISSUE   | operand captured, start pulse being issued
// WAIT    | conversion in flight, waiting for converter done
// DELIVER | result registered, done pulse to the winner
module bcd_conv_arbiter
   import bcd_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 32,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*WIDTH-1:0] i_bin,
   output logic [N_REQ-1:0]       o_ack,
   output logic [N_REQ-1:0]       o_done,
   output logic [BCD_W-1:0]       o_bcd,
   output logic [3:0]             o_dp,
   output logic                   o_busy,
   output logic                   o_timeout,
   output logic                   o_conv_start,
   output logic [WIDTH-1:0]       o_conv_bin,
   input  logic                   i_conv_ready,
   input  logic                   i_conv_done,
   input  logic [BCD_W-1:0]       i_conv_bcd,
   input  logic [3:0]             i_conv_dp
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("bcd_conv_arbiter: unsupported parameter set");
   end

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [IDX_W-1:0]   ptr_nxt;
   logic [WIDTH-1:0]   bin_q, bin_d;
   logic [WIDTH-1:0]   bin_sel;
   bcd7_t              bcd_q, bcd_d;
   logic [3:0]         dp_q, dp_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic               start_q, start_d;
   logic               tmo_q, tmo_d;
   logic [N_REQ-1:0]   gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic               wdog_tc;

   rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
      .req_i (i_req),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   always_comb begin
      bin_sel = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt[k]) begin
            bin_sel = i_bin[k*WIDTH +: WIDTH];
         end
      end
   end

   assign ptr_nxt = (win_q == IDX_W'(N_REQ-1)) ? '0 : win_q + IDX_W'(1);

`ifdef BCD_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wdog_q, wdog_d;

   // Down-counter loaded on WAIT entry; terminal count lands TIMEOUT_CYC cycles in.
   always_comb begin
      wdog_d = wdog_q;
      if (state_q == ISSUE) begin
         wdog_d = WD_W'(TIMEOUT_CYC - 1);
      end else if (state_q == WAIT && wdog_q != '0) begin
         wdog_d = wdog_q - WD_W'(1);
      end
   end

   assign wdog_tc = (state_q == WAIT) && (wdog_q == '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign wdog_tc = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      dp_d    = dp_q;
      ack_d   = '0;
      done_d  = '0;
      start_d = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_any && i_conv_ready) begin
               win_d   = gnt_idx;
               bin_d   = bin_sel;
               ack_d   = gnt;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            start_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            // A done arriving on the terminal-count cycle still wins.
            if (i_conv_done) begin
               bcd_d   = i_conv_bcd;
               dp_d    = i_conv_dp;
               state_d = DELIVER;
            end else if (wdog_tc) begin
               tmo_d   = 1'b1;
               ptr_d   = ptr_nxt;
               state_d = IDLE;
            end
         end
         DELIVER: begin
            done_d  = N_REQ'(1) << win_q;
            ptr_d   = ptr_nxt;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         dp_q    <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         start_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         dp_q    <= dp_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         start_q <= start_d;
         tmo_q   <= tmo_d;
      end
   end

   // Pulses are registered, so each appears the cycle after the state that raises it.
   assign o_ack        = ack_q;
   assign o_done       = done_q;
   assign o_bcd        = bcd_q;
   assign o_dp         = dp_q;
   assign o_busy       = (state_q != IDLE);
   assign o_timeout    = tmo_q;
   assign o_conv_start = start_q;
   assign o_conv_bin   = bin_q;

endmodule
